// File: rtl/alu_cmd_driver_pkg.sv
// Shared definitions for the mini-ALU pin interface: opcodes, driver state
// encoding, bus bit positions and small pack/check helpers.
package alu_cmd_driver_pkg;

    localparam int ALU_W = 6;

    // ALU control codes as seen on {ui_in[7:6], uio_in[7:6]}
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;

    // Driver FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Result bus layout: {zero, carry, data[5:0]}
    localparam int UO_ZERO_BIT  = 7;
    localparam int UO_CARRY_BIT = 6;

    // Opcodes above SLT have no ALU meaning and are never put on the pins
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_SLT);
    endfunction

    // ui_in carries the upper opcode bits above operand A
    function automatic logic [7:0] pack_ui(input logic [3:0] op, input logic [ALU_W-1:0] a);
        return {op[3:2], a};
    endfunction

    // uio_in carries the lower opcode bits above operand B
    function automatic logic [7:0] pack_uio(input logic [3:0] op, input logic [ALU_W-1:0] b);
        return {op[1:0], b};
    endfunction

    // A healthy ALU raises zero exactly when the data field is all zeros
    function automatic logic zero_mismatch(input logic [7:0] uo);
        return (uo[UO_ZERO_BIT] != (uo[ALU_W-1:0] == {ALU_W{1'b0}}));
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Initiator for the 6-bit mini-ALU: takes one command at a time over
// valid/ready, drives it onto the registered ALU input pins for a settle
// window, samples the result bus and returns it over valid/ready.
module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int WIDTH         = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [7:0]       alu_ui,
    output logic [7:0]       alu_uio,
    input  logic [7:0]       alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [15:0]      op_count
);

    // Counter reload: the capture happens on the edge where the counter is 0
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic             r_illegal;
    logic             r_cmd_ready;
    logic [7:0]       r_ui;
    logic [7:0]       r_uio;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_carry;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    logic [15:0]      r_op_count;

    logic             w_accept;
    logic [1:0]       w_next_state;

    // Next-state decode; an accepted command always passes through DRIVE so
    // even an illegal opcode answers one cycle after acceptance
    always_comb begin
        w_accept     = (r_state == ST_IDLE) && r_cmd_ready && cmd_valid;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_DRIVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, pin drive, response capture and completion counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_illegal   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_ui        <= 8'd0;
            r_uio       <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {WIDTH{1'b0}};
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_ready <= (w_next_state == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && op_is_legal(cmd_op)) begin
                        r_illegal <= 1'b0;
                        r_ui      <= pack_ui(cmd_op, cmd_a);
                        r_uio     <= pack_uio(cmd_op, cmd_b);
                        r_cnt     <= SETTLE_LOAD;
                    end else begin
                        // Illegal opcodes never reach the pins
                        r_illegal <= w_accept;
                        r_ui      <= 8'd0;
                        r_uio     <= 8'd0;
                        r_cnt     <= 4'd0;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == 4'd0) begin
                        r_ui        <= 8'd0;
                        r_uio       <= 8'd0;
                        r_rsp_valid <= 1'b1;
                        if (r_illegal) begin
                            r_rsp_data  <= {WIDTH{1'b0}};
                            r_rsp_carry <= 1'b0;
                            r_rsp_zero  <= 1'b0;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_rsp_data  <= alu_res[WIDTH-1:0];
                            r_rsp_carry <= alu_res[UO_CARRY_BIT];
                            r_rsp_zero  <= alu_res[UO_ZERO_BIT];
                            r_rsp_err   <= zero_mismatch(alu_res);
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_op_count != 16'hFFFF) begin
                            r_op_count <= r_op_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_ui        <= 8'd0;
                    r_uio       <= 8'd0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign alu_ui    = r_ui;
    assign alu_uio   = r_uio;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;
    assign op_count  = r_op_count;

endmodule
